// File: rtl/de_pkg.sv
// Shared definitions for the decoder family that sits on the pe3 encoder link.
package de_pkg;

  localparam int unsigned CODE_W   = 3;
  localparam int unsigned ONEHOT_W = 8;

  // Code-to-one-hot decode; a disabled input decodes to all-zero.
  function automatic logic [ONEHOT_W-1:0] dec_onehot(input logic en,
                                                     input logic [CODE_W-1:0] code);
    return en ? (ONEHOT_W'(1) << code) : '0;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; no full-FIFO pass-through.
module sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [W-1:0]  wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push;
  logic          pop;

  // Handshake qualifiers and show-ahead head, all from registered state.
  always_comb begin
    wr_ready = (count != CW'(DEPTH));
    rd_valid = (count != '0);
    push     = wr_valid & wr_ready;
    pop      = rd_valid & rd_ready;
    rd_data  = rd_valid ? mem[rd_ptr] : '0;
  end

  // Storage array; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy update; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
                                   count <= CW'(DEPTH))
    else $error("sync_fifo count out of range: %0d", count);

endmodule

// File: rtl/de3_fifo.sv
// 3-to-8 one-hot decoder feeding a small FIFO, with a sticky codes-seen mask.
module de3_fifo
  import de_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_en,
  input  logic [CODE_W-1:0]   in_code,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ONEHOT_W-1:0] out_y,
  output logic [CW-1:0]       count,
  output logic [ONEHOT_W-1:0] seen,
  input  logic                seen_clr
);

  logic [ONEHOT_W-1:0] y_new;
  logic                push;

  // Input-side decode and push qualifier.
  always_comb begin
    y_new = dec_onehot(in_en, in_code);
    push  = in_valid & in_ready;
  end

  sync_fifo #(
    .W     (ONEHOT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  (y_new),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (out_y),
    .count    (count)
  );

  // Sticky mask; a push in the clearing cycle is ORed in after the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) seen <= '0;
    else        seen <= (seen_clr ? '0 : seen) | (push ? y_new : '0);
  end

endmodule

// File: tb/tb_de3_fifo.sv
// Directed, table-driven bench for de3_fifo (DEPTH=4).
module tb_de3_fifo;
  import de_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_en, out_ready, seen_clr;
  logic [2:0] in_code;
  logic       in_ready, out_valid;
  logic [7:0] out_y, seen;
  logic [2:0] count;

  int n_assert = 0;
  int n_fail   = 0;

  de3_fifo #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_en     (in_en),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .count     (count),
    .seen      (seen),
    .seen_clr  (seen_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v, en;
    logic [2:0] code;
    logic       ordy, clr;
    logic       e_rdy, e_ov;
    logic [7:0] e_y;
    logic [2:0] e_cnt;
    logic [7:0] e_seen;
  } vec_t;

  function automatic vec_t mk(input logic v, en, input logic [2:0] code,
                              input logic ordy, clr, input logic e_rdy, e_ov,
                              input logic [7:0] e_y, input logic [2:0] e_cnt,
                              input logic [7:0] e_seen);
    vec_t r;
    r.v = v; r.en = en; r.code = code; r.ordy = ordy; r.clr = clr;
    r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_y = e_y; r.e_cnt = e_cnt; r.e_seen = e_seen;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, en, input logic [2:0] code, input logic ordy, clr);
    in_valid = v; in_en = en; in_code = code; out_ready = ordy; seen_clr = clr;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t   vecs[22];
  logic [7:0] q[$];
  logic   do_push, do_pop;
  logic [2:0] c;

  initial begin
    // v, en, code, ordy, clr | rdy, ov, y, cnt, seen
    vecs[0]  = mk(1,1,0,0,0, 1,1,8'h01,1,8'h01);
    vecs[1]  = mk(1,1,1,0,0, 1,1,8'h01,2,8'h03);
    vecs[2]  = mk(1,1,2,0,0, 1,1,8'h01,3,8'h07);
    vecs[3]  = mk(1,1,3,0,0, 0,1,8'h01,4,8'h0F);
    vecs[4]  = mk(1,1,4,0,0, 0,1,8'h01,4,8'h0F);
    vecs[5]  = mk(0,0,0,1,0, 1,1,8'h02,3,8'h0F);
    vecs[6]  = mk(0,0,0,1,0, 1,1,8'h04,2,8'h0F);
    vecs[7]  = mk(0,0,0,1,0, 1,1,8'h08,1,8'h0F);
    vecs[8]  = mk(0,0,0,1,0, 1,0,8'h00,0,8'h0F);
    vecs[9]  = mk(1,1,4,0,0, 1,1,8'h10,1,8'h1F);
    vecs[10] = mk(1,1,5,0,0, 1,1,8'h10,2,8'h3F);
    vecs[11] = mk(1,1,6,0,0, 1,1,8'h10,3,8'h7F);
    vecs[12] = mk(1,1,7,0,0, 0,1,8'h10,4,8'hFF);
    vecs[13] = mk(0,0,0,1,0, 1,1,8'h20,3,8'hFF);
    vecs[14] = mk(0,0,0,1,0, 1,1,8'h40,2,8'hFF);
    vecs[15] = mk(0,0,0,1,0, 1,1,8'h80,1,8'hFF);
    vecs[16] = mk(0,0,0,1,0, 1,0,8'h00,0,8'hFF);
    vecs[17] = mk(0,0,0,0,1, 1,0,8'h00,0,8'h00);
    vecs[18] = mk(1,0,5,0,0, 1,1,8'h00,1,8'h00);
    vecs[19] = mk(0,0,0,1,0, 1,0,8'h00,0,8'h00);
    vecs[20] = mk(1,1,3,0,1, 1,1,8'h08,1,8'h08);
    vecs[21] = mk(0,0,0,1,1, 1,0,8'h00,0,8'h00);

    // Reset held for two edges, then idle state.
    rst_n = 1'b0;
    drive(0,0,0,0,0);
    step();
    step();
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready",  32'(in_ready),  32'd1);
    check("reset count",     32'(count),     32'd0);
    check("reset seen",      32'(seen),      32'h00);
    check("reset out_y",     32'(out_y),     32'h00);

    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].en, vecs[i].code, vecs[i].ordy, vecs[i].clr);
      step();
      check($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'(vecs[i].e_rdy));
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("vec%0d out_y", i),     32'(out_y),     32'(vecs[i].e_y));
      check($sformatf("vec%0d count", i),     32'(count),     32'(vecs[i].e_cnt));
      check($sformatf("vec%0d seen", i),      32'(seen),      32'(vecs[i].e_seen));
    end

    // Fill to full, then stream with both sides active across several wraps.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      c = 3'((i + 3) % 8);
      drive(1,1,c,0,0);
      q.push_back(dec_onehot(1'b1, c));
      step();
    end
    check("fill count", 32'(count), 32'd4);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      c = 3'((i + 5) % 8);
      drive(1,1,c,1,0);
      do_push = (q.size() != 4);
      do_pop  = (q.size() != 0);
      step();
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(dec_onehot(1'b1, c));
      if (i == 0) check("full both count", 32'(count), 32'd3);
      if (i == 1) check("held count",      32'(count), 32'd3);
      check($sformatf("stream%0d count", i), 32'(count), 32'(q.size()));
      check($sformatf("stream%0d out_y", i), 32'(out_y), 32'(q.size() != 0 ? q[0] : 8'h00));
    end

    // Reset mid-transfer with both handshakes active.
    @(negedge clk);
    rst_n = 1'b0;
    drive(1,1,2,1,0);
    step();
    check("midrst count",     32'(count),     32'd0);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst seen",      32'(seen),      32'h00);
    check("midrst in_ready",  32'(in_ready),  32'd1);

    @(negedge clk);
    rst_n = 1'b1;
    drive(1,1,6,0,0);
    step();
    check("postrst out_valid", 32'(out_valid), 32'd1);
    check("postrst out_y",     32'(out_y),     32'h40);
    check("postrst count",     32'(count),     32'd1);
    check("postrst seen",      32'(seen),      32'h40);

    @(negedge clk);
    drive(0,0,0,0,0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
